ifetch_q: RTL and testbench
===========================

IFETCH_Q -- requirements
Module: ifetch_q

Interface
REQ-001 Parameter AW, default 16: instruction address width in words.
REQ-002 Parameter DEPTH, default 2: prefetch queue entries; legal values are 2 or 4.
REQ-003 clk  input  1  system clock; all state SHALL update on the positive edge.
REQ-004 rst_f  input  1  reset, asynchronous and active-low; only rst_f == 0 SHALL hold the block in reset.
REQ-005 br_taken  input  1  one-cycle redirect request from control.
REQ-006 pc_in  input  AW  redirect target, sampled when br_taken == 1.
REQ-007 fetch_en  input  1  the IR side can accept an instruction this cycle.
REQ-008 mem_rd  output  1  read request to instruction memory.
REQ-009 mem_addr  output  AW  word address of the request.
REQ-010 mem_ack  input  1  one-cycle response strobe from memory; mem_data is valid in the same cycle.
REQ-011 mem_data  input  32  instruction word returned by memory.
REQ-012 ir_load  output  1  load strobe to the IR.
REQ-013 read_data  output  32  instruction presented to the IR.
REQ-014 pc_out  output  AW  address of the instruction on read_data.

Function
REQ-015 The block SHALL contain a fetch address register fpc, a DEPTH-entry FIFO of {addr, data} pairs, and a request FSM with three states: IDLE, WAIT and DISCARD.
REQ-016 IDLE -> WAIT SHALL occur when count + 1 <= DEPTH and br_taken == 0.
  - On that edge, mem_rd SHALL be set to 1 and mem_addr SHALL be set to fpc.
REQ-017 In WAIT, mem_rd and mem_addr SHALL remain stable until mem_ack arrives; at most one request SHALL be outstanding.
REQ-018 WAIT with mem_ack == 1 and br_taken == 0:
  - {mem_addr, mem_data} SHALL be pushed into the FIFO;
  - fpc SHALL advance to fpc + 1, modulo 2^AW, so that 'hFFFF wraps to 0;
  - the FSM SHALL go to WAIT with the new address if space remains after the push, otherwise to IDLE with mem_rd = 0.
REQ-019 ir_load SHALL equal fetch_en & !empty & !br_taken, combinationally.
  - read_data and pc_out SHALL show the FIFO head.
  - The head SHALL be popped on the edge where ir_load == 1.
  - When the FIFO is empty, read_data SHALL be 0.
REQ-020 A push and a pop in the same cycle SHALL both take effect and leave count unchanged; a push into a full FIFO SHALL be impossible by construction.
REQ-021 br_taken == 1 SHALL:
  - flush the FIFO (count = 0);
  - load fpc with pc_in;
  - suppress ir_load in that cycle.
REQ-022 br_taken in WAIT without mem_ack SHALL move the FSM to DISCARD.
  - mem_rd and mem_addr SHALL hold their old values until mem_ack arrives.
  - The acknowledged data SHALL be dropped.
  - The FSM SHALL then go to WAIT with mem_addr = the new fpc.
REQ-023 br_taken in WAIT together with mem_ack SHALL drop the data and issue the request for pc_in on the next cycle.
REQ-024 br_taken in DISCARD SHALL reload fpc only, with the most recent pc_in taking precedence.
REQ-025 A request in flight SHALL continue to be served while the FIFO drains; instruction order at the IR SHALL equal fetch address order.
REQ-026 In steady state, with fetch_en held at 1 and single-cycle ack, throughput SHALL be one instruction per two cycles or better.

Reset
REQ-027 While rst_f == 0, and immediately on assertion:
  - mem_rd = 0, mem_addr = 0, fpc = 0;
  - FIFO empty, ir_load = 0, read_data = 0, pc_out = 0;
  - FSM in IDLE.
REQ-028 The first request after rst_f rises SHALL be for address 0, issued on the first clk edge.
REQ-029 Reset asserted while a request is in WAIT SHALL abandon that request; a mem_ack arriving after reset SHALL be ignored, because the FSM is in IDLE.

Verification
REQ-030 Reset release, memory acking 1 cycle after each mem_rd with data = 0xA000_0000 + addr, fetch_en = 1 -> IR receives 0xA0000000, 0xA0000001, 0xA0000002 in order, with pc_out equal to 0, 1, 2.
REQ-031 fetch_en = 0 for 10 cycles -> exactly DEPTH entries are fetched, mem_rd then stays 0 and ir_load stays 0; raising fetch_en -> addresses 0..DEPTH-1 are delivered, then fetching resumes.
REQ-032 br_taken with pc_in = 0x0040 while the WAIT request for addr 3 is unacked -> memory sees addr 3 held until ack, then addr 0x0040; data for addr 3 never reaches the IR; the next ir_load shows pc_out = 0x0040.
REQ-033 fpc preset to 0xFFFF via branch -> consecutive pc_out values 0xFFFF, 0x0000.
REQ-034 rst_f pulsed low asynchronously between edges during WAIT -> mem_rd falls immediately; the late mem_ack is ignored; after release, the first mem_addr is 0.

Source files
------------

// File: rtl/ifetch_q.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_q
//  Purpose  : Instruction prefetch queue. Issues one memory read at a time
//             and buffers {addr, data} pairs for the IR. Redirects flush the
//             queue and discard any response that is still in flight.
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_q #(
    parameter int AW    = 16,
    parameter int DEPTH = 2     // 2 or 4; pointers rely on a power of two
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          br_taken,
    input  logic [AW-1:0] pc_in,
    input  logic          fetch_en,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_data,
    output logic          ir_load,
    output logic [31:0]   read_data,
    output logic [AW-1:0] pc_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] c_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] c_FULL_M1 = CW'(DEPTH - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT    = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [AW-1:0] r_fpc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [AW-1:0] r_q_addr [DEPTH];
    logic [31:0]   r_q_data [DEPTH];

    logic          w_empty;
    logic          w_space;
    logic          w_push;
    logic [AW-1:0] w_fpc_next;
    logic          w_rd_next;
    logic [AW-1:0] w_addr_next;

    assign w_empty   = (r_count == '0);
    assign ir_load   = fetch_en & ~w_empty & ~br_taken;
    assign read_data = w_empty ? 32'd0 : r_q_data[r_rd_ptr];
    assign pc_out    = w_empty ? '0    : r_q_addr[r_rd_ptr];

    // While a request is outstanding count < DEPTH, so a simultaneous pop
    // always leaves room; otherwise room remains only below DEPTH-1.
    assign w_space = ir_load | (r_count < c_FULL_M1);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!br_taken && (r_count < c_FULL)) begin
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (mem_ack) begin
                    w_next_state = (br_taken || w_space) ? c_WAIT : c_IDLE;
                end else if (br_taken) begin
                    w_next_state = c_DISCARD;
                end
            end
            c_DISCARD: begin
                if (mem_ack) begin
                    w_next_state = c_WAIT;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_push     = (r_state == c_WAIT) && mem_ack && !br_taken;
        w_fpc_next = r_fpc;
        if (br_taken) begin
            w_fpc_next = pc_in;
        end else if (w_push) begin
            w_fpc_next = r_fpc + AW'(1);
        end
        w_rd_next   = (w_next_state != c_IDLE);
        w_addr_next = mem_addr;
        if (r_state == c_IDLE) begin
            if (w_next_state == c_WAIT) begin
                w_addr_next = r_fpc;
            end
        end else if (mem_ack) begin
            // The bus address is held until the response; then it follows fpc.
            w_addr_next = w_fpc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            r_fpc    <= '0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            mem_rd   <= w_rd_next;
            mem_addr <= w_addr_next;
            r_fpc    <= w_fpc_next;
            if (br_taken) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (ir_load) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push && !ir_load) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && ir_load) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Storage is qualified by r_count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= mem_addr;
            r_q_data[r_wr_ptr] <= mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_q
//  Purpose  : Self-checking bench for ifetch_q with a latency-randomised
//             memory and an in-order instruction stream reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_q;

    localparam int AW    = 16;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_f;
    logic          br_taken;
    logic [AW-1:0] pc_in;
    logic          fetch_en;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_data;
    logic          ir_load;
    logic [31:0]   read_data;
    logic [AW-1:0] pc_out;

    int            n_pass  = 0;
    int            n_total = 0;

    // Reference: the next instruction address the IR must receive.
    logic [AW-1:0] exp_pc;
    int            loads;
    int            stall;

    bit            mem_manual;
    bit            man_ack;
    logic [31:0]   man_data;
    int            lat_max;
    bit            tracking;
    int            remain;
    logic [AW-1:0] req_addr;
    int            ack_cnt;
    bit            found;

    ifetch_q #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .br_taken  (br_taken),
        .pc_in     (pc_in),
        .fetch_en  (fetch_en),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .ir_load   (ir_load),
        .read_data (read_data),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory: answers each request after 1..lat_max cycles with A000_0000+addr.
    initial begin
        mem_ack  = 1'b0;
        mem_data = 32'd0;
        tracking = 1'b0;
        remain   = 0;
        req_addr = '0;
        ack_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_manual) begin
                tracking = 1'b0;
                mem_ack  = man_ack;
                mem_data = man_data;
                if (man_ack) ack_cnt++;
            end else begin
                mem_ack = 1'b0;
                if (!rst_f) begin
                    tracking = 1'b0;
                end else if (tracking) begin
                    chk("req_held", 32'(mem_rd), 32'd1);
                    chk("req_addr_held", 32'(mem_addr), 32'(req_addr));
                    remain--;
                    if (remain == 0) begin
                        mem_ack  = 1'b1;
                        mem_data = 32'hA000_0000 + 32'(mem_addr);
                        tracking = 1'b0;
                        ack_cnt++;
                    end
                end else if (mem_rd) begin
                    tracking = 1'b1;
                    req_addr = mem_addr;
                    remain   = int'($urandom_range(lat_max, 1));
                end
            end
        end
    end

    // One cycle of stimulus; every IR load must be the next address in order.
    task automatic cyc(input bit fe, input bit br, input logic [AW-1:0] pc);
        @(negedge clk);
        fetch_en = fe;
        br_taken = br;
        pc_in    = pc;
        #1;
        if (br || !fe) chk("ir_load_suppressed", 32'(ir_load), 32'd0);
        if (ir_load === 1'b1) begin
            chk("pc_out", 32'(pc_out), 32'(exp_pc));
            chk("read_data", read_data, 32'hA000_0000 + 32'(exp_pc));
            exp_pc++;
            loads++;
            stall = 0;
        end else if (fe && !br) begin
            chk("empty_read_data", read_data, 32'd0);
            stall++;
            chk("no_starvation", 32'(stall < 24), 32'd1);
        end
        if (br) begin
            exp_pc = pc;
            stall  = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        fetch_en = 1'b1;
        br_taken = 1'b0;
        rst_f    = 1'b0;
        #1;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ir_load", 32'(ir_load), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_f  = 1'b1;
        exp_pc = '0;
        stall  = 0;
        @(posedge clk);
        #1;
        chk("first_req_rd", 32'(mem_rd), 32'd1);
        chk("first_req_addr", 32'(mem_addr), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_f      = 1'b0;
        br_taken   = 1'b0;
        fetch_en   = 1'b0;
        pc_in      = '0;
        mem_manual = 1'b0;
        man_ack    = 1'b0;
        man_data   = 32'd0;
        lat_max    = 1;
        exp_pc     = '0;
        loads      = 0;
        stall      = 0;

        // Reset state, then in-order stream and throughput with 1-cycle ack.
        do_reset();
        repeat (40) cyc(1'b1, 1'b0, '0);
        chk("stream_0_1_2", 32'(exp_pc >= 3), 32'd1);
        chk("throughput", 32'(loads >= 18), 32'd1);

        // Stalled IR: queue fills to DEPTH, then drains in order and resumes.
        do_reset();
        ack_cnt = 0;
        repeat (10) cyc(1'b0, 1'b0, '0);
        chk("fill_count", 32'(ack_cnt), 32'(DEPTH));
        chk("idle_when_full", 32'(mem_rd), 32'd0);
        loads = 0;
        repeat (20) cyc(1'b1, 1'b0, '0);
        chk("drain_resume", 32'(loads >= DEPTH + 3), 32'd1);

        // Redirect while the request for addr 3 is unacknowledged.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, '0);
            if (mem_rd && mem_addr == 16'd3 && !mem_ack) begin
                found = 1'b1;
                break;
            end
        end
        chk("found_req3", 32'(found), 32'd1);
        mem_manual = 1'b1;
        man_ack    = 1'b0;
        cyc(1'b1, 1'b1, 16'h0040);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk("discard_rd_hold", 32'(mem_rd), 32'd1);
            chk("discard_addr_hold", 32'(mem_addr), 32'd3);
        end
        man_data = 32'hA000_0003;
        man_ack  = 1'b1;
        cyc(1'b1, 1'b0, '0);
        chk("discard_ack_addr", 32'(mem_addr), 32'd3);
        man_ack = 1'b0;
        cyc(1'b1, 1'b0, '0);
        chk("redirect_rd", 32'(mem_rd), 32'd1);
        chk("redirect_addr", 32'(mem_addr), 32'h0040);
        mem_manual = 1'b0;
        loads      = 0;
        repeat (12) cyc(1'b1, 1'b0, '0);
        chk("redirect_delivered", 32'(exp_pc > 16'h0040), 32'd1);

        // Redirect in the same cycle as an ack: data dropped, new request next.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, '0);
            if (mem_rd && !mem_ack) begin
                found = 1'b1;
                break;
            end
        end
        chk("found_req_phase", 32'(found), 32'd1);
        cyc(1'b1, 1'b1, 16'h0100);
        cyc(1'b1, 1'b0, '0);
        chk("ack_br_rd", 32'(mem_rd), 32'd1);
        chk("ack_br_addr", 32'(mem_addr), 32'h0100);
        repeat (10) cyc(1'b1, 1'b0, '0);

        // Address wrap at the top of the space.
        cyc(1'b1, 1'b1, 16'hFFFF);
        repeat (12) cyc(1'b1, 1'b0, '0);
        chk("wrap", 32'(exp_pc >= 2 && exp_pc < 16), 32'd1);

        // Asynchronous reset during WAIT, with a late ack after release.
        mem_manual = 1'b1;
        man_ack    = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, '0);
        chk("wait_before_rst", 32'(mem_rd), 32'd1);
        #2;
        rst_f = 1'b0;
        #1;
        chk("async_rst_rd", 32'(mem_rd), 32'd0);
        chk("async_rst_addr", 32'(mem_addr), 32'd0);
        man_data = 32'hDEAD_BEEF;
        man_ack  = 1'b1;
        @(negedge clk);
        rst_f   = 1'b1;
        exp_pc  = '0;
        stall   = 0;
        man_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_rd", 32'(mem_rd), 32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'd0);
        mem_manual = 1'b0;
        loads      = 0;
        repeat (20) cyc(1'b1, 1'b0, '0);
        chk("post_rst_stream", 32'(loads >= 5), 32'd1);

        // Randomised traffic: variable latency, IR stalls, redirects.
        lat_max = 3;
        loads   = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] pc;
            bit            fe;
            bit            br;
            fe = ($urandom_range(3, 0) != 0);
            br = ($urandom_range(19, 0) == 0);
            pc = ($urandom_range(3, 0) == 0) ? AW'(16'hFFFD + 16'($urandom_range(3, 0)))
                                             : AW'($urandom);
            cyc(fe, br, pc);
        end
        chk("random_progress", 32'(loads > 300), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
